clock_divider: RTL and testbench



---
 rtl/clock_divider_pkg.sv | 12 +
 rtl/clock_divider_if.sv | 16 +
 rtl/clock_divider_modn_counter.sv | 41 ++++
 rtl/clock_divider.sv | 65 ++++++
 tb/tb_clock_divider.sv | 122 ++++++++++++
 5 files changed

// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the integer clock divider.
package clock_divider_pkg;

    localparam int unsigned CLKDIV_DEFAULT_DIV = 100_000_000;
    localparam int unsigned SYS_CLK_HZ         = 100_000_000;

    // Division ratio that turns the system clock into target_hz.
    function automatic int unsigned div_for_hz(input int unsigned target_hz);
        return SYS_CLK_HZ / target_hz;
    endfunction

endpackage

// File: rtl/clock_divider_if.sv
// Output bundle of the clock divider; carries the enable input when CLKDIV_ENABLE_EN is defined.
interface clock_divider_if;

    logic clk_out;
    logic tick;
`ifdef CLKDIV_ENABLE_EN
    logic en;

    modport master (output clk_out, output tick, input en);
    modport slave  (input clk_out, input tick, output en);
`else
    modport master (output clk_out, output tick);
    modport slave  (input clk_out, input tick);
`endif

endinterface

// File: rtl/clock_divider_modn_counter.sv
// Modulo-N up counter with async active-high reset; optional hold input under CLKDIV_ENABLE_EN.
module clock_divider_modn_counter #(
    parameter  int unsigned N = 4,
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
`ifdef CLKDIV_ENABLE_EN
    input  logic         en_i,
`endif
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_next_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_inc;

    // cnt_next_o is the value the register takes on the coming edge, hold included.
    always_comb begin
        cnt_inc = (cnt_q == W'(N - 1)) ? '0 : cnt_q + W'(1);
        cnt_d   = cnt_inc;
`ifdef CLKDIV_ENABLE_EN
        if (!en_i) begin
            cnt_d = cnt_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign cnt_next_o = cnt_d;

endmodule

// File: rtl/clock_divider.sv
// Integer clock divider: registered square wave clk_out plus a strobe at each rising phase.
// Defining CLKDIV_ENABLE_EN adds an enable that freezes the phase and suppresses tick.
module clock_divider
    import clock_divider_pkg::*;
#(
    parameter int unsigned DIV = CLKDIV_DEFAULT_DIV
) (
    input  logic            clk,
    input  logic            rst,
    clock_divider_if.master div_if
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned LOW   = DIV - DIV / 2;

    if (DIV < 2) begin : g_bad_div
        $error("clock_divider: DIV must be at least 2");
    end

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             clk_out_q;
    logic             clk_out_d;
    logic             tick_q;
    logic             tick_d;

    clock_divider_modn_counter #(
        .N (DIV)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
`ifdef CLKDIV_ENABLE_EN
        .en_i       (div_if.en),
`endif
        .cnt_o      (cnt),
        .cnt_next_o (cnt_next)
    );

    // Outputs decode the counter's next value so they line up with the counter register.
    always_comb begin
        clk_out_d = (cnt_next >= CNT_W'(LOW));
        tick_d    = (cnt_next == CNT_W'(LOW));
`ifdef CLKDIV_ENABLE_EN
        if (!div_if.en) begin
            tick_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign div_if.clk_out = clk_out_q;
    assign div_if.tick    = tick_q;

    a_cnt_range: assert property (@(posedge clk) disable iff (rst) 32'(cnt) < DIV);

endmodule

// File: tb/tb_clock_divider.sv
// Scoreboard bench for clock_divider: several ratios share random reset/enable stimulus.
module tb_clock_divider;
    import clock_divider_pkg::*;

    localparam int unsigned NDUT = 4;
    localparam int unsigned DIVS [NDUT] = '{4, 5, 2, div_for_hz(10_000_000)};
    localparam int unsigned NCYC = 3000;

    logic clk;
    logic rst;
    logic en;

    clock_divider_if if0 ();
    clock_divider_if if1 ();
    clock_divider_if if2 ();
    clock_divider_if if3 ();

    clock_divider #(.DIV(DIVS[0])) u_d0 (.clk(clk), .rst(rst), .div_if(if0));
    clock_divider #(.DIV(DIVS[1])) u_d1 (.clk(clk), .rst(rst), .div_if(if1));
    clock_divider #(.DIV(DIVS[2])) u_d2 (.clk(clk), .rst(rst), .div_if(if2));
    clock_divider #(.DIV(DIVS[3])) u_d3 (.clk(clk), .rst(rst), .div_if(if3));

`ifdef CLKDIV_ENABLE_EN
    assign if0.en = en;
    assign if1.en = en;
    assign if2.en = en;
    assign if3.en = en;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2*NDUT-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Expected {clk_out, tick} from the number of enabled edges since reset release.
    function automatic logic [1:0] model(input int unsigned k, input int unsigned div,
                                         input logic en_edge);
        int unsigned ph;
        int unsigned low;
        ph  = k % div;
        low = div - div / 2;
        return {ph >= low, en_edge && (ph == low)};
    endfunction

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: {clk_out,tick} got %b, want %b", name, $time, act, exp);
        end
    endtask

    // Stimulus: random resets (some asserted between edges) and, if present, random enable.
    initial begin
        int unsigned k [NDUT];
        int hold;
        logic en_edge;
        logic [2*NDUT-1:0] e;
        for (int i = 0; i < NDUT; i++) k[i] = 0;
        rst  = 1'b1;
        en   = 1'b1;
        hold = 3;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            en_edge = en;
            for (int i = 0; i < NDUT; i++) begin
                if (rst) k[i] = 0;
                else if (en) k[i] = k[i] + 1;
            end
            #2;
            if (rst) begin
                hold--;
                if (hold <= 0) rst = 1'b0;
            end else if ($urandom_range(0, 99) < 2) begin
                rst  = 1'b1;
                hold = int'($urandom_range(1, 3));
            end
`ifdef CLKDIV_ENABLE_EN
            en = ($urandom_range(0, 3) != 0);
`endif
            e = '0;
            for (int i = 0; i < NDUT; i++) begin
                if (rst) begin
                    k[i] = 0;
                end else begin
                    e[2*i +: 2] = model(k[i], DIVS[i], en_edge);
                end
            end
            exp_q.push_back(e);
        end
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Monitor: the outputs are presented every cycle; compare mid-cycle.
    initial begin
        logic [2*NDUT-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL underflow at %0t: no expected entry, want one", $time);
            end else begin
                e = exp_q.pop_front();
                check("div4",  {if0.clk_out, if0.tick}, e[1:0]);
                check("div5",  {if1.clk_out, if1.tick}, e[3:2]);
                check("div2",  {if2.clk_out, if2.tick}, e[5:4]);
                check("div10", {if3.clk_out, if3.tick}, e[7:6]);
            end
        end
    end

endmodule
